// File: rtl/vv_coin_sequencer.sv
// -----------------------------------------------------------------------------
// vv_coin_sequencer
//
// Converts start/coin button presses into timed coin and start pulses for the
// game core. A player-1 start becomes one coin pulse, then a start-1 pulse.
// A player-2 start becomes two coin pulses, then a start-2 pulse. A dedicated
// coin press becomes one coin pulse with no start. All pulse and gap lengths
// are counted in video frames (VBLANK rising edges).
//
// Ports:
//   CLK         system clock
//   RESET_N     asynchronous active-low reset
//   ENA         clock enable; all state advances only when high
//   VBLANK      vertical blank; its rising edge is the frame tick
//   START1_REQ  player-1 start button level
//   START2_REQ  player-2 start button level
//   COIN_REQ    dedicated coin button level
//   COIN        coin line to the core (active-high, registered)
//   START1      player-1 start line (active-high, registered)
//   START2      player-2 start line (active-high, registered)
//   BUSY        high whenever a sequence is in progress
// -----------------------------------------------------------------------------
module vv_coin_sequencer #(
  parameter int COIN_FRAMES  = 4,
  parameter int GAP_FRAMES   = 4,
  parameter int START_FRAMES = 4,
  parameter int CNT_W        = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic ENA,
  input  logic VBLANK,
  input  logic START1_REQ,
  input  logic START2_REQ,
  input  logic COIN_REQ,
  output logic COIN,
  output logic START1,
  output logic START2,
  output logic BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COIN_ON,
    ST_COIN_GAP,
    ST_START_ON
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_P1,
    SEL_P2
  } sel_t;

  localparam logic [CNT_W-1:0] COIN_LIM  = CNT_W'(COIN_FRAMES);
  localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(GAP_FRAMES);
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_FRAMES);

  // Input bit order: 0 = VBLANK, 1 = START1, 2 = START2, 3 = COIN
  logic [3:0] in_sync_q;
  logic [3:0] in_prev_q;
  logic [3:0] in_rise;

  state_t           state_q, state_d;
  sel_t             sel_q, sel_d;
  logic [1:0]       coins_q, coins_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             pend1_q, pend1_d;
  logic             pend2_q, pend2_d;
  logic             coin_q, start1_q, start2_q, busy_q;
  logic             tick;

  assign in_rise = in_sync_q & ~in_prev_q;
  assign tick    = in_rise[0];
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    coins_d = coins_q;
    cnt_d   = cnt_q;
    // Start presses latch in any state; a repeat press while pending is absorbed.
    pend1_d = pend1_q | in_rise[1];
    pend2_d = pend2_q | in_rise[2];

    case (state_q)
      ST_IDLE: begin
        // pend*_d already includes a same-cycle start edge, so it launches now.
        if (pend1_d) begin
          pend1_d = 1'b0;
          coins_d = 2'd1;
          sel_d   = SEL_P1;
          state_d = ST_COIN_ON;
          cnt_d   = '0;
        end else if (pend2_d) begin
          pend2_d = 1'b0;
          coins_d = 2'd2;
          sel_d   = SEL_P2;
          state_d = ST_COIN_ON;
          cnt_d   = '0;
        end else if (in_rise[3]) begin
          coins_d = 2'd1;
          sel_d   = SEL_NONE;
          state_d = ST_COIN_ON;
          cnt_d   = '0;
        end
      end

      ST_COIN_ON: begin
        if (tick) begin
          if (cnt_inc == COIN_LIM) begin
            state_d = ST_COIN_GAP;
            coins_d = coins_q - 2'd1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_COIN_GAP: begin
        if (tick) begin
          if (cnt_inc == GAP_LIM) begin
            cnt_d = '0;
            if (coins_q != 2'd0) begin
              state_d = ST_COIN_ON;
            end else if (sel_q == SEL_NONE) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_START_ON;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_START_ON: begin
        if (tick) begin
          if (cnt_inc == START_LIM) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_sync_q <= '0;
      in_prev_q <= '0;
      state_q   <= ST_IDLE;
      sel_q     <= SEL_NONE;
      coins_q   <= '0;
      cnt_q     <= '0;
      pend1_q   <= 1'b0;
      pend2_q   <= 1'b0;
      coin_q    <= 1'b0;
      start1_q  <= 1'b0;
      start2_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else if (ENA) begin
      in_sync_q <= {COIN_REQ, START2_REQ, START1_REQ, VBLANK};
      in_prev_q <= in_sync_q;
      state_q   <= state_d;
      sel_q     <= sel_d;
      coins_q   <= coins_d;
      cnt_q     <= cnt_d;
      pend1_q   <= pend1_d;
      pend2_q   <= pend2_d;
      // Outputs decode the next state so they line up with the state register.
      coin_q    <= (state_d == ST_COIN_ON);
      start1_q  <= (state_d == ST_START_ON) && (sel_d == SEL_P1);
      start2_q  <= (state_d == ST_START_ON) && (sel_d == SEL_P2);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign COIN   = coin_q;
  assign START1 = start1_q;
  assign START2 = start2_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_vv_coin_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vv_coin_sequencer
//
// Self-checking bench for vv_coin_sequencer with COIN_FRAMES=2, GAP_FRAMES=1,
// START_FRAMES=3 and a frame tick every 100 enabled cycles. Each sequence is
// launched at frame phase 20, so the first coin pulse is 180 samples long and
// every later whole frame is 100 samples. Output activity is accumulated per
// scenario and compared with hand-computed totals.
// -----------------------------------------------------------------------------
module tb_vv_coin_sequencer;

  logic CLK = 1'b0;
  logic RESET_N;
  logic ENA;
  logic VBLANK;
  logic START1_REQ;
  logic START2_REQ;
  logic COIN_REQ;
  logic COIN;
  logic START1;
  logic START2;
  logic BUSY;

  vv_coin_sequencer #(
    .COIN_FRAMES (2),
    .GAP_FRAMES  (1),
    .START_FRAMES(3),
    .CNT_W       (4)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .ENA       (ENA),
    .VBLANK    (VBLANK),
    .START1_REQ(START1_REQ),
    .START2_REQ(START2_REQ),
    .COIN_REQ  (COIN_REQ),
    .COIN      (COIN),
    .START1    (START1),
    .START2    (START2),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string name;
    logic  s1;
    logic  s2;
    logic  c;
    int    exp_coin_rise;
    int    exp_coin_hi;
    int    exp_s1_hi;
    int    exp_s2_hi;
    int    exp_busy_hi;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;

  int   m_coin_rise, m_coin_hi, m_s1_hi, m_s2_hi, m_busy_hi, m_overlap;
  logic coin_last;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic clear_mon();
    m_coin_rise = 0;
    m_coin_hi   = 0;
    m_s1_hi     = 0;
    m_s2_hi     = 0;
    m_busy_hi   = 0;
    m_overlap   = 0;
    coin_last   = COIN;
  endtask

  // One clock: sample outputs on the falling edge, then advance the frame
  // generator. Only enabled cycles are counted and advance the generator.
  task automatic step();
    @(negedge CLK);
    if (ENA) begin
      if (COIN && !coin_last) m_coin_rise++;
      coin_last = COIN;
      if (COIN)   m_coin_hi++;
      if (START1) m_s1_hi++;
      if (START2) m_s2_hi++;
      if (BUSY)   m_busy_hi++;
      if (COIN && (START1 || START2)) m_overlap++;
      vcnt   = (vcnt + 1) % 100;
      VBLANK = (vcnt < 10);
    end
  endtask

  task automatic align();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (vcnt != 20 && n < 300);
    check("align_frame_phase", vcnt, 20);
  endtask

  task automatic check_totals(input string name, input int rise, input int chi,
                              input int s1hi, input int s2hi, input int bhi);
    check({name, "_coin_pulses"}, m_coin_rise, rise);
    check({name, "_coin_cycles"}, m_coin_hi, chi);
    check({name, "_start1_cycles"}, m_s1_hi, s1hi);
    check({name, "_start2_cycles"}, m_s2_hi, s2hi);
    check({name, "_busy_cycles"}, m_busy_hi, bhi);
    check({name, "_coin_start_overlap"}, m_overlap, 0);
  endtask

  vec_t vecs[4];
  int   bad;
  logic [3:0] snap;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"p1",     1'b1, 1'b0, 1'b0, 1, 180, 300,   0,  580};
    vecs[1] = '{"p2",     1'b0, 1'b1, 1'b0, 2, 380,   0, 300,  880};
    vecs[2] = '{"coin",   1'b0, 1'b0, 1'b1, 1, 180,   0,   0,  280};
    vecs[3] = '{"p1p2",   1'b1, 1'b1, 1'b0, 3, 579, 300, 300, 1479};

    // ---------------- reset hold with random inputs ----------------
    RESET_N    = 1'b0;
    ENA        = 1'b1;
    VBLANK     = 1'b0;
    START1_REQ = 1'b0;
    START2_REQ = 1'b0;
    COIN_REQ   = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      START1_REQ = 1'($urandom);
      START2_REQ = 1'($urandom);
      COIN_REQ   = 1'($urandom);
      step();
      VBLANK = 1'($urandom);
      if (COIN || START1 || START2 || BUSY) bad++;
    end
    check("reset_hold_nonzero_samples", bad, 0);
    check("reset_coin", int'(COIN), 0);
    check("reset_start1", int'(START1), 0);
    check("reset_start2", int'(START2), 0);
    check("reset_busy", int'(BUSY), 0);

    START1_REQ = 1'b0;
    START2_REQ = 1'b0;
    COIN_REQ   = 1'b0;
    step();
    RESET_N = 1'b1;
    clear_mon();
    repeat (300) step();
    check("release_busy_cycles", m_busy_hi, 0);
    check("release_coin_cycles", m_coin_hi, 0);

    // ---------------- table-driven sequences ----------------
    for (int v = 0; v < 4; v++) begin
      align();
      clear_mon();
      for (int i = 1; i <= 2000; i++) begin
        START1_REQ = vecs[v].s1 && (i <= 5);
        START2_REQ = vecs[v].s2 && (i <= 5);
        COIN_REQ   = vecs[v].c  && (i <= 5);
        step();
      end
      check_totals(vecs[v].name, vecs[v].exp_coin_rise, vecs[v].exp_coin_hi,
                   vecs[v].exp_s1_hi, vecs[v].exp_s2_hi, vecs[v].exp_busy_hi);
      check({vecs[v].name, "_busy_at_end"}, int'(BUSY), 0);
    end

    // ---------------- coin and repeat start presses while busy ----------------
    align();
    clear_mon();
    for (int i = 1; i <= 2000; i++) begin
      START1_REQ = (i <= 5) || (i >= 60 && i < 65) || (i >= 70 && i < 75) ||
                   (i >= 80 && i < 85);
      COIN_REQ   = (i >= 50 && i < 55);
      step();
    end
    START1_REQ = 1'b0;
    COIN_REQ   = 1'b0;
    check_totals("repeat", 2, 379, 600, 0, 1179);

    // ---------------- reset during second coin of P2 ----------------
    align();
    clear_mon();
    for (int i = 1; i <= 300; i++) begin
      START2_REQ = (i <= 5);
      step();
    end
    check("p2rst_coin_before_reset", int'(COIN), 1);
    check("p2rst_coin_pulses_before_reset", m_coin_rise, 2);
    RESET_N = 1'b0;
    #1;
    check("p2rst_async_coin", int'(COIN), 0);
    check("p2rst_async_busy", int'(BUSY), 0);
    check("p2rst_async_start2", int'(START2), 0);
    repeat (10) step();
    RESET_N = 1'b1;
    clear_mon();
    repeat (1000) step();
    check("p2rst_no_resume_busy", m_busy_hi, 0);
    check("p2rst_no_resume_coin", m_coin_hi, 0);

    // ---------------- ENA stall mid-sequence ----------------
    align();
    clear_mon();
    for (int i = 1; i <= 100; i++) begin
      START1_REQ = (i <= 5);
      step();
    end
    snap = {COIN, START1, START2, BUSY};
    check("stall_coin_before", int'(COIN), 1);
    ENA = 1'b0;
    bad = 0;
    repeat (500) begin
      step();
      if ({COIN, START1, START2, BUSY} != snap) bad++;
    end
    check("stall_frozen_changes", bad, 0);
    ENA = 1'b1;
    repeat (1400) step();
    check_totals("stall", 1, 180, 300, 0, 580);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vv_coin_sequencer.md
# vv_coin_sequencer

Credit/start sequencer between the MiSTer input decoding (keyboard/joystick start and coin buttons) and the game core's active-low IN0/IN1 registers. One start press turns into a timed sequence of coin pulses followed by a start pulse. Player 1 gets one coin and Player 2 gets two, all timed in video frames. Outputs are active-high; the top level inverts them into the input registers. The block replaces the "coin = start1 | start2" shortcut.

## Interface
Parameters:
- COIN_FRAMES, 4: frames each coin pulse is held high (≥1).
- GAP_FRAMES, 4: frames of low gap after each coin pulse (≥1).
- START_FRAMES, 4: frames the start pulse is held high (≥1).
- CNT_W, 4: frame counter width; must hold max(parameters).

Ports:
- CLK in 1: system clock (clk_sys).
- RESET_N in 1: asynchronous, active-low reset.
- ENA in 1: 6 MHz clock enable. All state changes occur only on CLK edges with ENA=1.
- VBLANK in 1: core vertical blank; its rising edge is the frame tick.
- START1_REQ in 1: player-1 start button level.
- START2_REQ in 1: player-2 start button level.
- COIN_REQ in 1: dedicated coin button level.
- COIN out 1: coin line to core, active-high.
- START1 out 1: player-1 start line, active-high.
- START2 out 1: player-2 start line, active-high.
- BUSY out 1: high whenever the FSM is not in IDLE.

## Operation
- Input sampling:
  - On ENA cycles, VBLANK, START1_REQ, START2_REQ and COIN_REQ pass through one sync register and one "previous" register.
  - A rising edge is sync=1, prev=0. The frame tick is the VBLANK rising edge.
- Pending latches:
  - pend1 and pend2 set on their START rising edge in any state.
  - A pending latch clears when its sequence is launched from IDLE.
  - A repeat press while pending is absorbed: one pending slot per player.
  - Coin rising edges are accepted only in IDLE and are otherwise dropped.
- FSM states: IDLE, COIN_ON, COIN_GAP, START_ON. Every state entry clears the frame counter.
- Launch from IDLE, priority pend1 > pend2 > coin edge:
  - pend1: coins_left=1, sel=P1, go COIN_ON.
  - pend2: coins_left=2, sel=P2, go COIN_ON.
  - Coin edge only: coins_left=1, sel=NONE, go COIN_ON.
  - A start edge in the same ENA cycle as IDLE counts as pending and launches that cycle.
- Frame counter: increments on each frame tick inside a state. A state exits on the tick that makes count reach its parameter.
- Transitions:
  - COIN_ON → COIN_GAP after COIN_FRAMES ticks; coins_left decrements on exit.
  - COIN_GAP, after GAP_FRAMES ticks:
    - coins_left≠0 → COIN_ON.
    - coins_left=0 and sel=NONE → IDLE.
    - coins_left=0 otherwise → START_ON.
  - START_ON → IDLE after START_FRAMES ticks.
- Outputs are registered and decoded from the next state:
  - COIN = (state==COIN_ON).
  - START1 = (state==START_ON && sel==P1).
  - START2 = (state==START_ON && sel==P2).
  - BUSY = (state≠IDLE).
- Both starts pressed in the same cycle: P1 sequence runs first. P2 stays pending and launches on the first ENA cycle back in IDLE.

## Timing
- Reset value of every output is 0. Reset state: IDLE, pend1=pend2=0, counters 0, sync/prev registers 0.
- RESET_N assertion mid-sequence forces all outputs low immediately (asynchronous). It discards pending requests and the partial sequence.
- Latency: a request that goes high before ENA edge k is synced at edge k and edge-detected at edge k+1. COIN and BUSY are high after edge k+1.
- Pulse lengths are counted in whole frame ticks, not in ENA cycles. The first COIN_ON frame may be partial, between 0 and 1 frame long.
- COIN and START are never high together. Adjacent coin pulses are separated by at least GAP_FRAMES-1 full frames plus a partial frame.
- With ENA low, all state holds, including edge detectors, so edges are not lost.
- Counter arithmetic is unsigned CNT_W bits. Wrap cannot occur, because exit happens at the parameter value.

## Test plan
Parameters COIN_FRAMES=2, GAP_FRAMES=1, START_FRAMES=3. VBLANK tick every 100 ENA cycles.
- Reset:
  - Stimulus: hold RESET_N=0 with random inputs.
  - Required: COIN=START1=START2=BUSY=0.
  - Stimulus: release with all inputs low.
  - Required: outputs stay 0.
- P1 start:
  - Stimulus: START1_REQ pulse.
  - Required: COIN high 2 ticks, low 1 tick, START1 high 3 ticks, then BUSY=0. START2 never asserts.
- P2 start:
  - Stimulus: START2_REQ pulse.
  - Required: exactly two COIN pulses of 2 ticks with a 1-tick gap, then START2 for 3 ticks.
- Simultaneous starts:
  - Stimulus: START1_REQ and START2_REQ rise in the same cycle.
  - Required: full P1 sequence, then the P2 sequence begins on the next ENA cycle after IDLE. Total COIN pulses = 3.
- Coin and repeat presses:
  - Stimulus: COIN_REQ pulse in IDLE.
  - Required: one 2-tick COIN pulse, no START.
  - Stimulus: COIN_REQ and three START1_REQ presses during BUSY.
  - Required: coin ignored; one further P1 sequence only.
- Reset mid-sequence and ENA stall:
  - Stimulus: RESET_N=0 during the second COIN of a P2 sequence.
  - Required: outputs drop to 0 without waiting for a clock edge; no sequence resumes after release.
  - Stimulus: ENA held low for 500 cycles mid-sequence.
  - Required: outputs frozen; sequence resumes unchanged when ENA returns.
